// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares a single memory bus (address / write data / write enable / read data)
// between two masters: M0 (CPU) and M1 (program loader / DMA). One master owns
// the bus at a time through a REQ/GNT handshake. The owner's address, write
// data and write strobe are muxed onto the bus, and read data is routed back
// to it one cycle later with an RVALID strobe. When both masters want the bus,
// the current owner is preempted after MAX_HOLD contended cycles.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   -> an IDLE tie goes to the master that did
//                                    not own the bus most recently.
//                       undefined -> an IDLE tie always goes to M0.
//   MAX_HOLD preemption applies in both builds.
//
// Parameters:
//   AW        address width
//   DW        data width
//   MAX_HOLD  max consecutive owned cycles while the other master requests
//             (0 = unlimited)
//
// Ports:
//   CLK            clock, all state changes on the rising edge
//   RST            synchronous active-high reset
//   Mx_REQ         master x requests / holds the bus
//   Mx_ADDR        master x address
//   Mx_WDATA       master x write data
//   Mx_WE          master x write enable (1 = write, 0 = read)
//   Mx_GNT         master x owns the bus this cycle (registered)
//   Mx_RDATA       read data to master x, zero unless Mx_RVALID
//   Mx_RVALID      read data valid for master x (registered)
//   MEM_ADDRESS    address to memory
//   MEM_DIN        write data to memory
//   MEM_EN_WRITE   write strobe to memory
//   MEM_DOUT       read data from memory (one cycle after the address)
//   OWNER          debug: 00 idle, 01 M0, 10 M1
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic          CLK,
  input  logic          RST,

  input  logic          M0_REQ,
  input  logic [AW-1:0] M0_ADDR,
  input  logic [DW-1:0] M0_WDATA,
  input  logic          M0_WE,
  output logic          M0_GNT,
  output logic [DW-1:0] M0_RDATA,
  output logic          M0_RVALID,

  input  logic          M1_REQ,
  input  logic [AW-1:0] M1_ADDR,
  input  logic [DW-1:0] M1_WDATA,
  input  logic          M1_WE,
  output logic          M1_GNT,
  output logic [DW-1:0] M1_RDATA,
  output logic          M1_RVALID,

  output logic [AW-1:0] MEM_ADDRESS,
  output logic [DW-1:0] MEM_DIN,
  output logic          MEM_EN_WRITE,
  input  logic [DW-1:0] MEM_DOUT,

  output logic [1:0]    OWNER
);

  // State encoding doubles as the one-hot grant vector and the OWNER value.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  // Hold counter must be at least one bit wide even when MAX_HOLD is 0.
  localparam int            HW         = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit            PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          last_owner_q, last_owner_d;   // 0 = M0, 1 = M1
  logic [1:0]    rvalid_q, rvalid_d;

  // Per-master views so the read path can be generated once for both masters.
  logic [1:0]    gnt;
  logic [1:0]    req;
  logic [1:0]    we;
  logic [DW-1:0] rdata [2];

  assign gnt = state_q;
  assign req = {M1_REQ, M0_REQ};
  assign we  = {M1_WE, M0_WE};

  // ---------------------------------------------------------------------------
  // Tie resolution from IDLE
  // ---------------------------------------------------------------------------
  state_t tie_state;
`ifdef ARB_ROUND_ROBIN_EN
  assign tie_state = last_owner_q ? OWN0 : OWN1;
`else
  assign tie_state = OWN0;
  // last_owner is still tracked in the fixed-priority build but nothing reads it.
  logic unused_last_owner;
  assign unused_last_owner = last_owner_q;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic   own_req;
  logic   oth_req;
  state_t oth_state;

  // Current owner's request, the waiting master's request and its state.
  assign own_req   = (state_q == OWN1) ? M1_REQ : M0_REQ;
  assign oth_req   = (state_q == OWN1) ? M0_REQ : M1_REQ;
  assign oth_state = (state_q == OWN1) ? OWN0   : OWN1;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;

    unique case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (M0_REQ && M1_REQ) begin
          state_d = tie_state;
        end else if (M0_REQ) begin
          state_d = OWN0;
        end else if (M1_REQ) begin
          state_d = OWN1;
        end
      end

      OWN0, OWN1: begin
        if (!own_req) begin
          // Owner released: hand straight to the waiting master, no idle bubble.
          state_d    = oth_req ? oth_state : IDLE;
          hold_cnt_d = '0;
        end else if (oth_req && PREEMPT_EN && (hold_cnt_q == HOLD_LAST)) begin
          state_d    = oth_state;
          hold_cnt_d = '0;
        end else if (oth_req) begin
          if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end else begin
          // Contention ended: the hold budget restarts.
          hold_cnt_d = '0;
        end
      end

      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase

    if ((state_d != state_q) && (state_d != IDLE)) begin
      last_owner_d = (state_d == OWN1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      last_owner_q <= 1'b1;   // so M0 wins the first tie in round-robin mode
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      rvalid_q     <= rvalid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path: a read in an owned cycle returns on the next cycle.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rvalid_d[gi] = gnt[gi] & req[gi] & ~we[gi];
    assign rdata[gi]    = rvalid_q[gi] ? MEM_DOUT : '0;
  end

  // ---------------------------------------------------------------------------
  // Bus mux: only the owner ever reaches memory. A write that coincides with
  // reset is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    MEM_ADDRESS  = '0;
    MEM_DIN      = '0;
    MEM_EN_WRITE = 1'b0;
    unique case (state_q)
      OWN0: begin
        MEM_ADDRESS  = M0_ADDR;
        MEM_DIN      = M0_WDATA;
        MEM_EN_WRITE = M0_REQ & M0_WE & ~RST;
      end
      OWN1: begin
        MEM_ADDRESS  = M1_ADDR;
        MEM_DIN      = M1_WDATA;
        MEM_EN_WRITE = M1_REQ & M1_WE & ~RST;
      end
      default: ;
    endcase
  end

  assign M0_GNT    = gnt[0];
  assign M1_GNT    = gnt[1];
  assign M0_RVALID = rvalid_q[0];
  assign M1_RVALID = rvalid_q[1];
  assign M0_RDATA  = rdata[0];
  assign M1_RDATA  = rdata[1];
  assign OWNER     = state_q;

endmodule
